// File: rtl/ternary_neuron_accum.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_neuron_accum
//  Description : Accumulate-and-threshold stage for a ternary neuron. Each
//                accepted beat carries two popcounts (matches against +1 and
//                -1 weights) for one input chunk. The block sums (pos - neg)
//                over NUM_CHUNKS beats. It then compares the sum against two
//                signed thresholds and emits a ternary activation.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    clr        in   1      synchronous abort of the partial sum (ACCUM only)
//    in_valid   in   1      beat valid
//    in_ready   out  1      block accepts a beat (high in ACCUM)
//    in_pos     in   POP_W  unsigned popcount, positive-weight matches
//    in_neg     in   POP_W  unsigned popcount, negative-weight matches
//    thresh_hi  in   ACC_W  signed upper threshold (sampled on last beat)
//    thresh_lo  in   ACC_W  signed lower threshold (sampled on last beat)
//    out_valid  out  1      result valid (high in DONE)
//    out_ready  in   1      consumer accepts the result
//    out_act    out  2      activation: 01 = +1, 11 = -1, 00 = 0
//    out_sum    out  ACC_W  signed final pre-activation sum
//    busy       out  1      frame in progress or result pending
// ============================================================================
module ternary_neuron_accum #(
    parameter int NUM_CHUNKS = 4,
    parameter int POP_W      = 5,
    parameter int ACC_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_pos,
    input  logic [POP_W-1:0] in_neg,
    input  logic [ACC_W-1:0] thresh_hi,
    input  logic [ACC_W-1:0] thresh_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The beat counter needs at least one bit, even when a frame is one beat long.
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    // Largest magnitude the sum can reach versus the largest positive value
    // the accumulator can hold.
    localparam longint C_MAX_MAG = ((longint'(1) << POP_W) - 1) * longint'(NUM_CHUNKS);
    localparam longint C_ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;

    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_DONE  = 1'b1;

    localparam logic [1:0] c_ACT_POS  = 2'b01;
    localparam logic [1:0] c_ACT_NEG  = 2'b11;
    localparam logic [1:0] c_ACT_ZERO = 2'b00;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (NUM_CHUNKS < 1) begin : g_bad_num_chunks
            $error("ternary_neuron_accum: NUM_CHUNKS must be >= 1");
        end
        if (C_ACC_MAX < C_MAX_MAG) begin : g_bad_acc_w
            $error("ternary_neuron_accum: ACC_W too narrow for POP_W*NUM_CHUNKS range");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_out_act;
    logic [ACC_W-1:0] r_out_sum;

    logic             w_in_accum;
    logic             w_abort;
    logic             w_accept;
    logic             w_last_beat;
    logic [ACC_W-1:0] w_delta;
    logic [ACC_W-1:0] w_acc_next;
    logic [1:0]       w_act_next;

    assign w_in_accum = (r_state == c_ST_ACCUM);

    // clr only acts in ACCUM and overrides any beat offered in the same cycle.
    // A pending result in DONE is never discarded by clr.
    assign w_abort     = w_in_accum & clr;
    assign w_accept    = w_in_accum & in_valid & ~clr;
    assign w_last_beat = w_accept & (r_cnt == c_LAST_CNT);

    // Both popcounts are zero-extended to ACC_W bits before the subtraction.
    // The modulo-2^ACC_W result is the correct two's-complement difference,
    // and the width check above guarantees the running sum never wraps.
    assign w_delta    = ACC_W'(in_pos) - ACC_W'(in_neg);
    assign w_acc_next = r_acc + w_delta;

    // The +1 test comes first, so it wins when thresh_lo > thresh_hi.
    always_comb begin
        w_act_next = c_ACT_ZERO;
        if ($signed(w_acc_next) > $signed(thresh_hi)) begin
            w_act_next = c_ACT_POS;
        end else if ($signed(w_acc_next) < $signed(thresh_lo)) begin
            w_act_next = c_ACT_NEG;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_ACCUM: begin
                if (w_last_beat) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_next_state = c_ST_ACCUM;
                end
            end
            default: begin
                w_next_state = c_ST_ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_ST_ACCUM: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            c_ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        busy = (r_cnt != '0) | (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------------------------
    // Datapath: partial sum, beat counter and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_act <= c_ACT_ZERO;
            r_out_sum <= '0;
        end else if (w_abort) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_last_beat) begin
            // Results are captured here and stay unchanged until the next
            // frame completes, including after the result is consumed.
            r_out_sum <= w_acc_next;
            r_out_act <= w_act_next;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_act = r_out_act;
    assign out_sum = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_ternary_neuron_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ternary_neuron_accum
//  Description : Directed self-checking bench for ternary_neuron_accum with
//                NUM_CHUNKS=4, POP_W=5, ACC_W=8. Inputs change on the falling
//                clock edge, and outputs are sampled there as well.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ternary_neuron_accum;

    localparam int NUM_CHUNKS = 4;
    localparam int POP_W      = 5;
    localparam int ACC_W      = 8;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [POP_W-1:0] in_pos;
    logic [POP_W-1:0] in_neg;
    logic [ACC_W-1:0] thresh_hi;
    logic [ACC_W-1:0] thresh_lo;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_act;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    int checks;
    int failures;

    ternary_neuron_accum #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .POP_W      (POP_W),
        .ACC_W      (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_th(input int hi, input int lo);
        thresh_hi = ACC_W'(hi);
        thresh_lo = ACC_W'(lo);
    endtask

    // Present one beat on the falling edge; it is accepted on the next rising edge.
    task automatic beat(input string tag, input int p, input int n);
        @(negedge clk);
        in_valid = 1'b1;
        in_pos   = POP_W'(p);
        in_neg   = POP_W'(n);
        check({tag, "_rdy"}, 32'(in_ready), 1);
    endtask

    task automatic beat4(input string tag, input int p, input int n);
        for (int i = 0; i < 4; i++) beat(tag, p, n);
    endtask

    // One cycle after the last beat: result must be presented.
    task automatic expect_result(input string tag, input int sum, input int act);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_sum"}, $signed(out_sum), sum);
        check({tag, "_act"}, 32'(out_act), act);
        check({tag, "_inrdy"}, 32'(in_ready), 0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vdrop"}, 32'(out_valid), 0);
        check({tag, "_rdyback"}, 32'(in_ready), 1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_neg    = '0;
        out_ready = 1'b0;
        set_th(5, -5);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_sum", $signed(out_sum), 0);
        check("rst_act", 32'(out_act), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_inrdy", 32'(in_ready), 1);

        // ---------------- basic +1: 8 + 0 - 1 + 4 = 11 ----------------
        beat("b1", 10, 2);
        beat("b1", 3, 3);
        beat("b1", 0, 1);
        check("b1_novalid", 32'(out_valid), 0);
        beat("b1", 4, 0);
        expect_result("b1", 11, 1);
        consume("b1");

        // ---------------- negative and zero ----------------
        beat4("neg", 0, 24);
        expect_result("neg", -96, 3);
        consume("neg");
        beat("zero", 5, 5);
        beat("zero", 1, 0);
        beat("zero", 0, 1);
        beat("zero", 2, 0);
        expect_result("zero", 2, 0);

        // clr while a result is pending is ignored
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("clrdone_valid", 32'(out_valid), 1);
        check("clrdone_sum", $signed(out_sum), 2);
        consume("zero");

        // ---------------- backpressure ----------------
        beat4("bp", 1, 0);
        expect_result("bp", 4, 0);
        in_valid = 1'b1;
        in_pos   = 5'd7;
        in_neg   = 5'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_inrdy", 32'(in_ready), 0);
            check("bp_hold_sum", $signed(out_sum), 4);
            check("bp_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ret_inrdy", 32'(in_ready), 1);
        check("bp_ret_busy", 32'(busy), 0);
        // The held beat is accepted on this edge; three more complete the frame.
        @(posedge clk);
        beat("bp2", 7, 0);
        beat("bp2", 7, 0);
        beat("bp2", 7, 0);
        expect_result("bp2", 28, 1);
        consume("bp2");

        // ---------------- threshold boundaries ----------------
        set_th(3, 3);
        beat("eq", 3, 0); beat("eq", 0, 0); beat("eq", 0, 0); beat("eq", 0, 0);
        expect_result("eq", 3, 0);
        consume("eq");
        beat4("gt", 1, 0);
        expect_result("gt", 4, 1);
        consume("gt");
        beat("lt", 2, 0); beat("lt", 0, 0); beat("lt", 0, 0); beat("lt", 0, 0);
        expect_result("lt", 2, 3);
        consume("lt");
        set_th(2, 7);
        beat("inv", 5, 0); beat("inv", 0, 0); beat("inv", 0, 0); beat("inv", 0, 0);
        expect_result("inv", 5, 1);
        consume("inv");

        // ---------------- abort with clr ----------------
        set_th(5, -5);
        beat("ab", 1, 0);
        beat("ab", 1, 0);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_pos   = 5'd9;
        in_neg   = 5'd0;
        @(posedge clk);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_novalid", 32'(out_valid), 0);
        beat4("ab2", 1, 0);
        expect_result("ab2", 4, 0);
        consume("ab2");

        // ---------------- overflow headroom ----------------
        beat4("ovp", 31, 0);
        expect_result("ovp", 124, 1);
        consume("ovp");
        beat4("ovn", 0, 31);
        expect_result("ovn", -124, 3);

        // ---------------- reset while a result is pending ----------------
        rst_n = 1'b0;
        #1;
        check("rstp_valid", 32'(out_valid), 0);
        check("rstp_sum", $signed(out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset mid-frame ----------------
        beat("rm", 20, 0);
        beat("rm", 20, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rm_valid", 32'(out_valid), 0);
        check("rm_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Partial sum of 40 must be gone: a fresh frame sums to 4.
        beat4("rm2", 1, 0);
        expect_result("rm2", 4, 0);
        consume("rm2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
